// File: rtl/sw_debounce.sv
// Debounces 18 raw board switches: two-flop synchronizer, shared sample-tick
// prescaler and a per-bit stability counter, with registered edge strobes.
module sw_debounce #(
  parameter int unsigned TICK_DIV     = 27000,
  parameter int unsigned STABLE_TICKS = 4
) (
  input  logic        clock,
  input  logic        nRst,
  input  logic [17:0] swIn,
  output logic [17:0] swOut,
  output logic [17:0] risePulse,
  output logic [17:0] fallPulse,
  output logic        anyChange
);

  localparam int unsigned NBITS = 18;
  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [2:0]       STAB_LAST = 3'(STABLE_TICKS - 1);

  logic [NBITS-1:0] sync1_q, sync2_q;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic [2:0]       stab_q [NBITS];
  logic [2:0]       stab_d [NBITS];
  logic [NBITS-1:0] sw_out_q, sw_out_d;
  logic [NBITS-1:0] rise_q, rise_d;
  logic [NBITS-1:0] fall_q, fall_d;
  logic             any_q, any_d;

  // With TICK_DIV = 1 the counter sits at 0 == TICK_LAST, so tick is constant high.
  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    stab_d   = stab_q;
    sw_out_d = sw_out_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < NBITS; i++) begin
      // Agreement clears progress even on a tick, so any bounce restarts the count.
      if (sync2_q[i] == sw_out_q[i]) begin
        stab_d[i] = '0;
      end else if (tick) begin
        if (stab_q[i] >= STAB_LAST) begin
          sw_out_d[i] = sync2_q[i];
          stab_d[i]   = '0;
          rise_d[i]   = sync2_q[i];
          fall_d[i]   = ~sync2_q[i];
        end else begin
          stab_d[i] = stab_q[i] + 3'd1;
        end
      end
    end
    any_d = |{rise_d, fall_d};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge nRst) begin
    if (!nRst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      tick_cnt_q <= '0;
      // NOTE: the stability counters are a tiny flop array, not RAM, so resetting
      // them is cheap and required to drop partial progress on reset.
      stab_q     <= '{default: '0};
      sw_out_q   <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      any_q      <= 1'b0;
    end else begin
      sync1_q    <= swIn;
      sync2_q    <= sync1_q;
      tick_cnt_q <= tick_cnt_d;
      stab_q     <= stab_d;
      sw_out_q   <= sw_out_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      any_q      <= any_d;
    end
  end

  assign swOut     = sw_out_q;
  assign risePulse = rise_q;
  assign fallPulse = fall_q;
  assign anyChange = any_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with TICK_DIV=4, STABLE_TICKS=3.
module tb_sw_debounce;

  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;
  localparam int LAT_MIN      = 2 + (STABLE_TICKS - 1) * TICK_DIV + 1;  // 11
  localparam int LAT_MAX      = 2 + STABLE_TICKS * TICK_DIV + 1;        // 15

  logic        clock = 1'b0;
  logic        nRst  = 1'b1;
  logic [17:0] swIn  = '0;
  logic [17:0] swOut, risePulse, fallPulse;
  logic        anyChange;

  int n_checks = 0;
  int n_errors = 0;

  sw_debounce #(.TICK_DIV(TICK_DIV), .STABLE_TICKS(STABLE_TICKS)) dut (
    .clock     (clock),
    .nRst      (nRst),
    .swIn      (swIn),
    .swOut     (swOut),
    .risePulse (risePulse),
    .fallPulse (fallPulse),
    .anyChange (anyChange)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Runs until swOut leaves base; lat = edges taken (0 if none), early = pulse seen before.
  task automatic wait_change(input logic [17:0] base, input int limit,
                             output int lat, output logic early);
    lat   = 0;
    early = 1'b0;
    for (int n = 1; n <= limit; n++) begin
      step();
      if (swOut !== base) begin
        lat = n;
        break;
      end
      if ((|risePulse) || (|fallPulse) || anyChange) early = 1'b1;
    end
  endtask

  task automatic quiet(input int cycles, output logic act);
    logic [17:0] base;
    base = swOut;
    act  = 1'b0;
    repeat (cycles) begin
      step();
      if ((swOut !== base) || (|risePulse) || (|fallPulse) || anyChange) act = 1'b1;
    end
  endtask

  task automatic check_edge(input string tag, input logic [17:0] base,
                            input logic [17:0] rise_exp, input logic [17:0] fall_exp);
    int          lat;
    logic        early;
    logic [17:0] after;
    after = (base | rise_exp) & ~fall_exp;
    wait_change(base, 40, lat, early);
    check({tag, "_lat_in_range"}, 32'(lat >= LAT_MIN && lat <= LAT_MAX), 32'd1);
    check({tag, "_no_early_pulse"}, 32'(early), 32'd0);
    check({tag, "_swOut"}, 32'(swOut), 32'(after));
    check({tag, "_rise"}, 32'(risePulse), 32'(rise_exp));
    check({tag, "_fall"}, 32'(fallPulse), 32'(fall_exp));
    check({tag, "_any"}, 32'(anyChange), 32'd1);
    step();
    check({tag, "_rise_off"}, 32'(risePulse), 32'd0);
    check({tag, "_fall_off"}, 32'(fallPulse), 32'd0);
    check({tag, "_any_off"}, 32'(anyChange), 32'd0);
    check({tag, "_swOut_hold"}, 32'(swOut), 32'(after));
  endtask

  initial begin
    logic act;
    logic acc;
    logic found;

    // Asynchronous reset before any clock edge.
    #1 nRst = 1'b0;
    #2;
    check("rst_swOut", 32'(swOut), 32'd0);
    check("rst_pulses", 32'(risePulse | fallPulse), 32'd0);
    check("rst_any", 32'(anyChange), 32'd0);
    repeat (3) step();
    nRst = 1'b1;

    // Idle with inputs low: tick on every 4th edge after release.
    acc = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      step();
      check("idle_tick", 32'(dut.tick), 32'((k % TICK_DIV) == TICK_DIV - 1));
      if ((|swOut) || (|risePulse) || (|fallPulse) || anyChange) acc = 1'b1;
    end
    check("idle_quiet", 32'(acc), 32'd0);

    // Single-bit rise.
    swIn[3] = 1'b1;
    check_edge("rise3", 18'h0, 18'h00008, 18'h0);

    // Six-cycle glitch must be filtered.
    swIn[5] = 1'b1;
    quiet(6, act);
    check("glitch5_high", 32'(act), 32'd0);
    swIn[5] = 1'b0;
    quiet(30, act);
    check("glitch5_after", 32'(act), 32'd0);

    // Back to all-zero, then all bits rise together.
    swIn = '0;
    check_edge("fall3", 18'h00008, 18'h0, 18'h00008);
    swIn = 18'h3FFFF;
    check_edge("all_rise", 18'h0, 18'h3FFFF, 18'h0);

    // Bit 7 chatter every 3 cycles, then a clean hold at 0.
    acc = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c % 3 == 0) swIn[7] = ~swIn[7];
      quiet(1, act);
      acc = acc | act;
    end
    check("chatter7_quiet", 32'(acc), 32'd0);
    swIn[7] = 1'b0;
    check_edge("fall7", 18'h3FFFF, 18'h0, 18'h00080);

    // Settle everything low, then reset in the middle of a bit-0 count.
    swIn = '0;
    check_edge("settle", 18'h3FF7F, 18'h0, 18'h3FF7F);
    swIn[0] = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (dut.stab_q[0] == 3'd2) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_mid_reached_stab2", 32'(found), 32'd1);
    nRst = 1'b0;
    #2;
    check("rst_mid_swOut", 32'(swOut), 32'd0);
    check("rst_mid_pulses", 32'(risePulse | fallPulse), 32'd0);
    check("rst_mid_any", 32'(anyChange), 32'd0);
    check("rst_mid_stab", 32'(dut.stab_q[0]), 32'd0);
    step();
    check("rst_mid_hold", 32'(swOut | risePulse | fallPulse), 32'd0);
    nRst = 1'b1;
    check_edge("rst_rise0", 18'h0, 18'h00001, 18'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
